// File: rtl/cmd_scheduler.sv
// rtl/cmd_scheduler.sv - timestamped command scheduler: FIFO fetch, time compare, bus write issue
module cmd_scheduler #(
    parameter int TIME_W = 32,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int CMD_W = TIME_W + DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] current_time,
    output logic              reset_time,
    input  logic              rel_mode,
    input  logic              enable,
    input  logic [CMD_W-1:0]  cmd_fifo_dout,
    input  logic              cmd_fifo_empty,
    input  logic              cmd_fifo_valid,
    output logic              cmd_fifo_rd_en,
    output logic [ADDR_W-1:0] cmd_bus_addr,
    output logic [DATA_W-1:0] cmd_bus_data,
    output logic              cmd_bus_en,
    output logic              cmd_bus_wr,
    output logic              cmd_bus_rd,
    input  logic              cmd_bus_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  late_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_ISSUE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [TIME_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  late_q, late_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_q, en_d;
    logic              rst_time_q, rst_time_d;
    logic              rd_en;

    logic [TIME_W-1:0] cmd_t;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] cmd_addr;
    logic [TIME_W-1:0] elapsed;
    logic              is_treset;
    logic              due;
    logic              late_hit;

    assign cmd_t     = cmd_q[CMD_W-1 -: TIME_W];
    assign cmd_data  = cmd_q[ADDR_W +: DATA_W];
    assign cmd_addr  = cmd_q[ADDR_W-1:0];
    assign is_treset = &cmd_addr;

    // Unsigned subtraction wraps modulo 2^TIME_W, so deltas stay correct across timer rollover.
    assign elapsed  = current_time - last_q;
    assign due      = (cmd_t == '0)
                    | (!rel_mode && (current_time >= cmd_t))
                    | ( rel_mode && (elapsed >= cmd_t));
    assign late_hit = (cmd_t != '0) && !rel_mode && (current_time > cmd_t);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        last_d     = last_q;
        issued_d   = issued_q;
        late_d     = late_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = en_q;
        rst_time_d = 1'b0;
        rd_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (enable && !cmd_fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmd_fifo_valid) begin
                    cmd_d   = cmd_fifo_dout;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (due) begin
                    if (late_hit && (late_q != '1)) begin
                        late_d = late_q + CNT_ONE;
                    end
                    if (is_treset) begin
                        // Timer-reset command: no bus access, just a one-cycle clear pulse.
                        rst_time_d = 1'b1;
                        last_d     = '0;
                        cmd_d      = '0;
                        state_d    = S_FETCH;
                    end else begin
                        en_d    = 1'b1;
                        addr_d  = cmd_addr;
                        data_d  = cmd_data;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_bus_ready) begin
                    en_d    = 1'b0;
                    addr_d  = '0;
                    data_d  = '0;
                    cmd_d   = '0;
                    last_d  = current_time;
                    state_d = S_FETCH;
                    if (issued_q != '1) begin
                        issued_d = issued_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            last_q     <= '0;
            issued_q   <= '0;
            late_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            rst_time_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            last_q     <= last_d;
            issued_q   <= issued_d;
            late_q     <= late_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            en_q       <= en_d;
            rst_time_q <= rst_time_d;
        end
    end

    assign cmd_fifo_rd_en = rd_en;
    assign cmd_bus_addr   = addr_q;
    assign cmd_bus_data   = data_q;
    assign cmd_bus_en     = en_q;
    assign cmd_bus_wr     = en_q;
    assign cmd_bus_rd     = 1'b0;
    assign reset_time     = rst_time_q;
    assign busy           = (state_q != S_FETCH);
    assign issued_cnt     = issued_q;
    assign late_cnt       = late_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// tb/tb_cmd_scheduler.sv - self-checking bench for cmd_scheduler
module tb_cmd_scheduler;

    localparam int TIME_W = 32;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int CMD_W  = TIME_W + DATA_W + ADDR_W;
    localparam int NV     = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [TIME_W-1:0] current_time;
    logic              reset_time;
    logic              rel_mode;
    logic              enable;
    logic [CMD_W-1:0]  cmd_fifo_dout;
    logic              cmd_fifo_empty;
    logic              cmd_fifo_valid;
    logic              cmd_fifo_rd_en;
    logic [ADDR_W-1:0] cmd_bus_addr;
    logic [DATA_W-1:0] cmd_bus_data;
    logic              cmd_bus_en;
    logic              cmd_bus_wr;
    logic              cmd_bus_rd;
    logic              cmd_bus_ready;
    logic              busy;
    logic [CNT_W-1:0]  issued_cnt;
    logic [CNT_W-1:0]  late_cnt;

    always #5 clk = ~clk;

    cmd_scheduler #(
        .TIME_W(TIME_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .current_time  (current_time),
        .reset_time    (reset_time),
        .rel_mode      (rel_mode),
        .enable        (enable),
        .cmd_fifo_dout (cmd_fifo_dout),
        .cmd_fifo_empty(cmd_fifo_empty),
        .cmd_fifo_valid(cmd_fifo_valid),
        .cmd_fifo_rd_en(cmd_fifo_rd_en),
        .cmd_bus_addr  (cmd_bus_addr),
        .cmd_bus_data  (cmd_bus_data),
        .cmd_bus_en    (cmd_bus_en),
        .cmd_bus_wr    (cmd_bus_wr),
        .cmd_bus_rd    (cmd_bus_rd),
        .cmd_bus_ready (cmd_bus_ready),
        .busy          (busy),
        .issued_cnt    (issued_cnt),
        .late_cnt      (late_cnt)
    );

    typedef struct {
        logic [31:0] start;
        int          len;
        logic [18:0] addr;
        logic [31:0] data;
    } obs_t;

    typedef struct {
        logic        rel;
        logic [31:0] ts;
        logic [31:0] t;
        logic [18:0] addr;
        logic [31:0] data;
        int          hold;
        int          exp_issues;
        logic [31:0] exp_start;
        int          exp_len;
        int          exp_late;
        int          exp_rt;
        logic [31:0] exp_rt_time;
    } vec_t;

    obs_t             obs_q[$];
    obs_t             exp_q[$];
    logic [CMD_W-1:0] fifo_q[$];
    int               hold_q[$];
    vec_t             vt[NV];
    vec_t             v;

    int          n_chk = 0;
    int          n_pass = 0;
    int          stable_err = 0;
    int          rt_cycles = 0;
    logic [31:0] rt_time = '0;
    int          rd_count = 0;
    int          hold_cur = 0;
    int          en_run = 0;
    logic        prev_en = 1'b0;
    logic        rd_s;
    logic [CNT_W-1:0] iss0, late0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [31:0] t, input logic [31:0] d,
                                            input logic [18:0] a);
        return {t, d, a};
    endfunction

    // One clock: observe at the falling edge, then update FIFO/timer/ready just after the rising edge.
    task automatic cyc();
        logic [95:0] junk;
        int          idx;
        @(negedge clk);
        rd_s = cmd_fifo_rd_en;
        if (rd_s) rd_count++;
        if (cmd_bus_rd) stable_err++;
        if (cmd_bus_en) begin
            if (!cmd_bus_wr) stable_err++;
            if (!prev_en) begin
                obs_q.push_back('{current_time, 1, cmd_bus_addr, cmd_bus_data});
            end else begin
                idx = obs_q.size() - 1;
                obs_q[idx].len = obs_q[idx].len + 1;
                if (obs_q[idx].addr !== cmd_bus_addr || obs_q[idx].data !== cmd_bus_data)
                    stable_err++;
            end
        end
        prev_en = cmd_bus_en;
        if (reset_time) begin
            rt_cycles++;
            rt_time = current_time;
        end
        @(posedge clk);
        #1;
        current_time = current_time + 32'd1;
        if (rd_s && fifo_q.size() > 0) begin
            cmd_fifo_dout  = fifo_q.pop_front();
            cmd_fifo_valid = 1'b1;
        end else begin
            junk           = {$urandom(), $urandom(), $urandom()};
            cmd_fifo_dout  = junk[CMD_W-1:0];
            cmd_fifo_valid = 1'b0;
        end
        cmd_fifo_empty = (fifo_q.size() == 0);
        if (cmd_bus_en) begin
            if (en_run == 0) hold_cur = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
            cmd_bus_ready = (en_run >= hold_cur);
            en_run++;
        end else begin
            en_run        = 0;
            cmd_bus_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic settle(input int bound, input string nm);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((n < 2 || busy || fifo_q.size() != 0) && n < bound);
        chk({nm, "_done"}, 64'(n < bound), 64'd1);
        cyc();
    endtask

    task automatic push(input logic [31:0] t, input logic [31:0] d, input logic [18:0] a,
                        input int h);
        fifo_q.push_back(mk(t, d, a));
        hold_q.push_back(h);
        cmd_fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fifo_q.delete();
        hold_q.delete();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
    endtask

    // Reference timeline: fetch at f, compare from f+2, issue the cycle after the first due time.
    task automatic rand_run(input logic rel, input int n);
        logic [31:0] f, e, d, last, t, dd;
        logic [18:0] a;
        int          h, late_m, m;
        do_reset();
        rel_mode     = rel;
        current_time = 32'd1000;
        obs_q.delete();
        exp_q.delete();
        f      = current_time;
        last   = '0;
        late_m = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) t = '0;
            else if (!rel) t = 32'd1000 + 32'($urandom_range(0, 25 * n));
            else t = 32'($urandom_range(1, 12));
            a  = 19'($urandom_range(0, 19'h7FFFE));
            dd = $urandom();
            h  = $urandom_range(0, 3);
            push(t, dd, a, h);
            e = f + 32'd2;
            if (t == '0) d = e;
            else if (!rel) d = (t > e) ? t : e;
            else d = (last + t > e) ? last + t : e;
            if (!rel && t != '0 && d > t) late_m++;
            exp_q.push_back('{d + 32'd1, h + 1, a, dd});
            last = d + 32'd1 + 32'(h);
            f    = last + 32'd1;
        end
        settle(4000, "rand");
        chk($sformatf("rand%0d_count", rel), 64'(obs_q.size()), 64'(n));
        m = (obs_q.size() < n) ? obs_q.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("rand%0d_%0d_start", rel, i), 64'(obs_q[i].start), 64'(exp_q[i].start));
            chk($sformatf("rand%0d_%0d_len", rel, i), 64'(obs_q[i].len), 64'(exp_q[i].len));
            chk($sformatf("rand%0d_%0d_addrdata", rel, i), {13'd0, obs_q[i].addr, obs_q[i].data},
                {13'd0, exp_q[i].addr, exp_q[i].data});
        end
        chk($sformatf("rand%0d_issued", rel), 64'(issued_cnt), 64'(n));
        chk($sformatf("rand%0d_late", rel), 64'(late_cnt), 64'(late_m));
    endtask

    initial begin
        // rel, ts, t, addr, data, hold, issues, start, len, late, rt, rt_time
        vt[0]  = '{1'b0, 32'd50,   32'd100, 19'h10,    32'hA5,       0, 1, 32'd101,  1, 0, 0, 32'd0};
        vt[1]  = '{1'b0, 32'd500,  32'd10,  19'h22,    32'h12345678, 0, 1, 32'd503,  1, 1, 0, 32'd0};
        vt[2]  = '{1'b0, 32'd200,  32'd0,   19'h3,     32'hDEADBEEF, 5, 1, 32'd203,  6, 0, 0, 32'd0};
        vt[3]  = '{1'b0, 32'd300,  32'd302, 19'h7FFFE, 32'h1,        0, 1, 32'd303,  1, 0, 0, 32'd0};
        vt[4]  = '{1'b0, 32'd400,  32'd401, 19'h44,    32'h2,        1, 1, 32'd403,  2, 1, 0, 32'd0};
        vt[5]  = '{1'b0, 32'd700,  32'd0,   19'h7FFFF, 32'h99,       0, 0, 32'd0,    0, 0, 1, 32'd703};
        vt[6]  = '{1'b1, 32'd1000, 32'd20,  19'h55,    32'hCAFE,     0, 1, 32'd1003, 1, 0, 0, 32'd0};
        vt[7]  = '{1'b1, 32'd1010, 32'd30,  19'h66,    32'hF00D,     2, 1, 32'd1034, 3, 0, 0, 32'd0};
        vt[8]  = '{1'b1, 32'd2000, 32'd0,   19'h0,     32'h0,        0, 1, 32'd2003, 1, 0, 0, 32'd0};
        vt[9]  = '{1'b1, 32'd3000, 32'd5,   19'h7FFFF, 32'h0,        0, 0, 32'd0,    0, 0, 1, 32'd3003};
        vt[10] = '{1'b0, 32'd60,   32'd60,  19'h1,     32'hFFFFFFFF, 0, 1, 32'd63,   1, 1, 0, 32'd0};
        vt[11] = '{1'b0, 32'd800,  32'd900, 19'h7FFFF, 32'h7,        0, 0, 32'd0,    0, 0, 1, 32'd901};

        rst            = 1'b0;
        current_time   = '0;
        rel_mode       = 1'b0;
        enable         = 1'b1;
        cmd_fifo_dout  = '0;
        cmd_fifo_empty = 1'b0;
        cmd_fifo_valid = 1'b0;
        cmd_bus_ready  = 1'b0;

        #3;
        chk("rst_en", 64'(cmd_bus_en), 64'd0);
        chk("rst_wr", 64'(cmd_bus_wr), 64'd0);
        chk("rst_rd", 64'(cmd_bus_rd), 64'd0);
        chk("rst_addr", 64'(cmd_bus_addr), 64'd0);
        chk("rst_data", 64'(cmd_bus_data), 64'd0);
        chk("rst_reset_time", 64'(reset_time), 64'd0);
        chk("rst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
        chk("rst_issued", 64'(issued_cnt), 64'd0);
        chk("rst_late", 64'(late_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        cyc();
        cyc();
        rst = 1'b1;
        chk("release_idle_busy", 64'(busy), 64'd1);
        cyc();
        chk("release_fetch_busy", 64'(busy), 64'd0);
        chk("release_no_rd_en", 64'(cmd_fifo_rd_en), 64'd0);

        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            rel_mode     = v.rel;
            current_time = v.ts;
            obs_q.delete();
            hold_q.delete();
            rt_cycles = 0;
            rt_time   = '0;
            iss0      = issued_cnt;
            late0     = late_cnt;
            push(v.t, v.data, v.addr, v.hold);
            settle(300, $sformatf("v%0d", i));
            chk($sformatf("v%0d_issues", i), 64'(obs_q.size()), 64'(v.exp_issues));
            if (obs_q.size() > 0 && v.exp_issues > 0) begin
                chk($sformatf("v%0d_start", i), 64'(obs_q[0].start), 64'(v.exp_start));
                chk($sformatf("v%0d_len", i), 64'(obs_q[0].len), 64'(v.exp_len));
                chk($sformatf("v%0d_addr", i), 64'(obs_q[0].addr), 64'(v.addr));
                chk($sformatf("v%0d_data", i), 64'(obs_q[0].data), 64'(v.data));
            end
            chk($sformatf("v%0d_issued_inc", i), 64'(CNT_W'(issued_cnt - iss0)), 64'(v.exp_issues));
            chk($sformatf("v%0d_late_inc", i), 64'(CNT_W'(late_cnt - late0)), 64'(v.exp_late));
            chk($sformatf("v%0d_rt_cycles", i), 64'(rt_cycles), 64'(v.exp_rt));
            if (v.exp_rt > 0) chk($sformatf("v%0d_rt_time", i), 64'(rt_time), 64'(v.exp_rt_time));
        end

        // enable low blocks fetches, but does not abort a command already fetched
        rel_mode     = 1'b0;
        enable       = 1'b0;
        current_time = 32'd100;
        obs_q.delete();
        hold_q.delete();
        push(32'd120, 32'hB0B, 19'h5A, 0);
        rd_count = 0;
        repeat (5) cyc();
        chk("en0_no_rd_en", 64'(rd_count), 64'd0);
        chk("en0_not_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        settle(100, "en0");
        chk("en0_one_fetch", 64'(rd_count), 64'd1);
        chk("en0_issues", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) chk("en0_start", 64'(obs_q[0].start), 64'd121);
        enable = 1'b1;

        // relative mode, plain and across timer wrap
        rel_mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            current_time = (k == 0) ? 32'd997 : 32'hFFFFFFED;
            obs_q.delete();
            hold_q.delete();
            push(32'd20, 32'h100 + 32'(k), 19'h11, 0);
            push(32'd20, 32'h200 + 32'(k), 19'h12, 0);
            settle(200, $sformatf("rel%0d", k));
            chk($sformatf("rel%0d_issues", k), 64'(obs_q.size()), 64'd2);
            if (obs_q.size() == 2) begin
                chk($sformatf("rel%0d_first", k), 64'(obs_q[0].start),
                    (k == 0) ? 64'd1000 : 64'hFFFFFFF0);
                chk($sformatf("rel%0d_second", k), 64'(obs_q[1].start),
                    (k == 0) ? 64'd1021 : 64'd5);
            end
        end
        rel_mode = 1'b0;

        // asynchronous reset in the middle of a stalled issue
        current_time = 32'd50;
        obs_q.delete();
        hold_q.delete();
        push(32'd0, 32'h5555, 19'h77, 10);
        begin
            int k;
            k = 0;
            while (!cmd_bus_en && k < 20) begin
                cyc();
                k++;
            end
            chk("midrst_reached_issue", 64'(k < 20), 64'd1);
        end
        cyc();
        cyc();
        chk("midrst_en_before", 64'(cmd_bus_en), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_en", 64'(cmd_bus_en), 64'd0);
        chk("midrst_wr", 64'(cmd_bus_wr), 64'd0);
        chk("midrst_addr", 64'(cmd_bus_addr), 64'd0);
        chk("midrst_data", 64'(cmd_bus_data), 64'd0);
        chk("midrst_reset_time", 64'(reset_time), 64'd0);
        chk("midrst_issued", 64'(issued_cnt), 64'd0);
        chk("midrst_late", 64'(late_cnt), 64'd0);
        chk("midrst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
        fifo_q.delete();
        hold_q.delete();
        rst = 1'b1;
        chk("midrst_idle", 64'(busy), 64'd1);
        cyc();
        chk("midrst_fetch", 64'(busy), 64'd0);
        current_time = 32'd5000;
        obs_q.delete();
        push(32'd0, 32'h1234, 19'h78, 0);
        settle(100, "midrst_next");
        chk("midrst_next_issues", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) begin
            chk("midrst_next_start", 64'(obs_q[0].start), 64'd5003);
            chk("midrst_next_addr", 64'(obs_q[0].addr), 64'h78);
        end
        chk("midrst_next_issued", 64'(issued_cnt), 64'd1);

        rand_run(1'b0, 16);
        rand_run(1'b1, 16);

        chk("bus_stable_wr_rd", 64'(stable_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
